// File: rtl/intercon_arb_ctrl_pkg.sv
// intercon_arb_ctrl_pkg: shared master count, arbiter state encodings and default stall limit
package intercon_arb_ctrl_pkg;
    localparam int INTERCON_MASTER_NUM = 4;
    localparam int INTERCON_ARB_TIMEOUT = 255;
    typedef enum logic {
        INTERCON_ARB_IDLE = 1'b0,
        INTERCON_ARB_BUSY = 1'b1
    } arb_state_e;
endpackage

// File: rtl/intercon_arb_ctrl_arbiter.sv
// intercon_arb_ctrl_arbiter: combinational round-robin pick of the nearest requester above the last grant
module intercon_arb_ctrl_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] pick
);
    // Larger distances are visited first, so the nearest requester is the final write
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 1; k--)
            for (int i = 0; i < N; i++)
                if (last[i] && req[(i + k) % N]) begin
                    pick = '0;
                    pick[(i + k) % N] = 1'b1;
                end
    end
endmodule

// File: rtl/intercon_arb_ctrl.sv
// intercon_arb_ctrl: registered round-robin bus ownership and slave-side mux; stall timeout under INTERCON_ARB_TIMEOUT_EN
module intercon_arb_ctrl
    import intercon_arb_ctrl_pkg::*;
#(
    parameter int MASTER_NUM = INTERCON_MASTER_NUM,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT = INTERCON_ARB_TIMEOUT
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [MASTER_NUM-1:0]            m_cyc_i,
    input  logic [MASTER_NUM-1:0]            m_stb_i,
    input  logic [MASTER_NUM-1:0]            m_we_i,
    input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_dat_i,
    input  logic [MASTER_NUM*DATA_WIDTH/8-1:0] m_sel_i,
    output logic [MASTER_NUM-1:0]            m_ack_o,
    output logic [MASTER_NUM-1:0]            m_err_o,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    output logic [DATA_WIDTH/8-1:0]          s_sel_o,
    input  logic                             s_ack_i,
    input  logic                             s_err_i,
    input  logic [DATA_WIDTH-1:0]            s_dat_i,
    output logic [MASTER_NUM-1:0]            grant_o,
    output logic                             busy_o,
    output logic                             timeout_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [MASTER_NUM-1:0] LAST_RST = 1 << (MASTER_NUM - 1);

    arb_state_e state_q, state_d;
    logic [MASTER_NUM-1:0] grant_q, grant_d, last_q, last_d, rr_pick, pick;
    logic timeout;

    intercon_arb_ctrl_arbiter #(.N(MASTER_NUM)) u_arbiter (
        .req  (m_cyc_i),
        .last (last_q),
        .pick (rr_pick)
    );

    // A lone requester that also held the bus last is re-granted rather than starved
    assign pick = |rr_pick ? rr_pick : (m_cyc_i & last_q);

`ifdef INTERCON_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    assign timeout = (state_q == INTERCON_ARB_BUSY) && (cnt_q == 16'(TIMEOUT));
    // Count strobed cycles without a slave response; any response or idle restarts it
    always_ff @(posedge clk_i)
        if (rst_i || state_q == INTERCON_ARB_IDLE || s_ack_i || s_err_i || timeout) cnt_q <= '0;
        else if (s_stb_o) cnt_q <= cnt_q + 16'd1;
`else
    assign timeout = 1'b0 & (TIMEOUT == 0);
`endif

    // Grant on request in IDLE; hold until the owner drops cyc or stalls out
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == INTERCON_ARB_IDLE) begin
            if (|m_cyc_i) begin
                grant_d = pick;
                state_d = INTERCON_ARB_BUSY;
            end
        end else if (!(|(m_cyc_i & grant_q)) || timeout) begin
            last_d  = grant_q;
            grant_d = '0;
            state_d = INTERCON_ARB_IDLE;
        end
    end

    // Ownership registers
    always_ff @(posedge clk_i)
        if (rst_i) begin
            state_q <= INTERCON_ARB_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end

    // One-hot AND-OR mux of the owner's request onto the slave side; all zero without an owner
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            s_cyc_o = s_cyc_o | (m_cyc_i[i] & grant_q[i]);
            s_stb_o = s_stb_o | (m_stb_i[i] & grant_q[i]);
            s_we_o  = s_we_o | (m_we_i[i] & grant_q[i]);
            s_adr_o = s_adr_o | (m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
            s_dat_o = s_dat_o | (m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
            s_sel_o = s_sel_o | (m_sel_i[i*SW +: SW] & {SW{grant_q[i]}});
        end
    end

    assign m_ack_o   = {MASTER_NUM{s_ack_i}} & grant_q;
    assign m_err_o   = {MASTER_NUM{s_err_i | timeout}} & grant_q;
    assign m_dat_o   = s_dat_i;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q == INTERCON_ARB_BUSY);
    assign timeout_o = timeout;
endmodule

// File: tb/tb_intercon_arb_ctrl.sv
// tb_intercon_arb_ctrl: directed vectors for grant rotation, muxing, response routing, reset and timeout
module tb_intercon_arb_ctrl;
    localparam int N = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat = '0;
    logic [N*DW/8-1:0] m_sel = '0;
    logic [N-1:0] m_ack, m_err, grant;
    logic [DW-1:0] m_rdat, s_dat, s_rdat = '0;
    logic s_cyc, s_stb, s_we, s_ack = 1'b0, s_err = 1'b0, busy, tmo;
    logic [AW-1:0] s_adr;
    logic [DW/8-1:0] s_sel;
    int vectors = 0;
    int miscompares = 0;
    logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    intercon_arb_ctrl #(
        .MASTER_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
`ifdef INTERCON_ARB_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_rdat),
        .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_scyc", s_cyc, 0);
        check("rst_ack", m_ack, 0);
        check("rst_tmo", tmo, 0);
        // single request from m0
        m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
        m_adr[0 +: AW] = 32'h1000; m_dat[0 +: DW] = 32'hCAFE_0000; m_sel[0 +: 4] = 4'hF;
        m_adr[3*AW +: AW] = 32'h3000;
        check("req_cycle_grant", grant, 0);
        step();
        check("t1_grant", grant, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_adr", s_adr, 32'h1000);
        check("t1_scyc", s_cyc, 1);
        check("t1_we", s_we, 1);
        check("t1_dat", s_dat, 32'hCAFE_0000);
        check("t1_sel", s_sel, 4'hF);
        s_ack = 1'b1; s_rdat = 32'h5A5A_1234;
        #1;
        check("t1_ack", m_ack, 4'b0001);
        check("t1_rdat", m_rdat, 32'h5A5A_1234);
        m_cyc = '0; m_stb = '0; m_we = '0;
        step();
        s_ack = 1'b0;
        check("t1_rel_grant", grant, 0);
        check("t1_rel_busy", busy, 0);
        // full rotation from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_cyc = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_grant", grant, exp_g[k]);
            check("rr_busy", busy, 1);
            m_cyc = 4'b1111 & ~exp_g[k];
            step();
            check("rr_gap", grant, 0);
            m_cyc = 4'b1111;
        end
        // sole repeat requester m2
        m_cyc = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            check("solo_grant", grant, 4'b0100);
            m_cyc = '0;
            step();
            check("solo_gap", busy, 0);
            m_cyc = 4'b0100;
        end
        // m1 owns; non-owner activity ignored; response routing
        m_cyc = 4'b0010;
        step();
        check("m1_grant", grant, 4'b0010);
        m_cyc = 4'b0011;
        step();
        check("m1_hold", grant, 4'b0010);
        s_ack = 1'b1; s_err = 1'b1;
        #1;
        check("m1_ack", m_ack, 4'b0010);
        check("m1_err", m_err, 4'b0010);
        s_ack = 1'b0; s_err = 1'b0;
        m_cyc = '0;
        step();
        s_ack = 1'b1;
        #1;
        check("idle_ack", m_ack, 0);
        s_ack = 1'b0;
        // reset while m3 owns; last returns to reset value
        m_cyc = 4'b1000;
        step();
        check("m3_grant", grant, 4'b1000);
        check("m3_adr", s_adr, 32'h3000);
        rst = 1'b1;
        step();
        check("rst_mid_grant", grant, 0);
        check("rst_mid_scyc", s_cyc, 0);
        rst = 1'b0;
        m_cyc = 4'b1001;
        step();
        check("post_rst_grant", grant, 4'b0001);
        m_cyc = '0;
        step();
`ifdef INTERCON_ARB_TIMEOUT_EN
        m_cyc = 4'b0001; m_stb = 4'b0001;
        step();
        check("to_grant", grant, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            check("to_early", tmo, 0);
            step();
        end
        check("to_pulse", tmo, 1);
        check("to_err", m_err, 4'b0001);
        step();
        check("to_scyc", s_cyc, 0);
        check("to_tmo_off", tmo, 0);
        check("to_grant_rel", grant, 0);
        m_cyc = '0; m_stb = '0;
        step();
`else
        m_cyc = 4'b0001; m_stb = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            step();
            check("no_tmo", tmo, 0);
        end
        check("no_tmo_grant", grant, 4'b0001);
        m_cyc = '0; m_stb = '0;
        step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/intercon_arb_ctrl.md
Name: intercon_arb_ctrl

Overview:
Sequential front end of the i2d SoC intercon.
- Registers the round-robin grant and holds bus ownership for a whole Wishbone cycle.
- Keeps the last-grant history that the combinational arbiter needs.
- Multiplexes the owning master's request signals onto the shared slave-side bus.
- Routes ack/err/data back to the owner only.

Parameters:
MASTER_NUM, `INTERCON_MASTER_NUM (4), number of masters
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
TIMEOUT, 255, stalled-cycle limit (used only with the optional feature)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
m_cyc_i  in  MASTER_NUM  per-master cycle request
m_stb_i  in  MASTER_NUM  per-master strobe
m_we_i  in  MASTER_NUM  per-master write enable
m_adr_i  in  MASTER_NUM*ADDR_WIDTH  flattened addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_i  in  MASTER_NUM*DATA_WIDTH  flattened write data
m_sel_i  in  MASTER_NUM*DATA_WIDTH/8  flattened byte selects
m_ack_o  out  MASTER_NUM  per-master ack
m_err_o  out  MASTER_NUM  per-master error
m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
s_cyc_o, s_stb_o, s_we_o  out  1  muxed controls to slave side
s_adr_o  out  ADDR_WIDTH  muxed address
s_dat_o  out  DATA_WIDTH  muxed write data
s_sel_o  out  DATA_WIDTH/8  muxed byte selects
s_ack_i, s_err_i  in  1  slave response
s_dat_i  in  DATA_WIDTH  slave read data
grant_o  out  MASTER_NUM  registered one-hot grant
busy_o  out  1  bus owned
timeout_o  out  1  timeout pulse

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - state=IDLE, grant_q=0, last_q=1<<(MASTER_NUM-1), so master 0 has top priority first.
  - All outputs 0.
- Round-robin pick, computed from m_cyc_i and last_q:
  - Use the nearest requester above last_q, excluding last_q itself.
  - If that pick is zero but (m_cyc_i & last_q) is nonzero, re-grant last_q. A sole repeat requester is never starved.
- State IDLE:
  - If |m_cyc_i: grant_q<=pick, state<=BUSY.
  - Grant is visible one cycle after the request.
- State BUSY:
  - grant_q holds.
  - When m_cyc_i[owner]==0: last_q<=grant_q, grant_q<=0, state<=IDLE.
  - There is exactly one idle cycle between owners.
  - Requests arriving in the release cycle are served in the following IDLE cycle.
- Slave-side mux is combinational from grant_q:
  - s_* = fields of the owner.
  - All zero when grant_q==0, so s_cyc_o=0 in IDLE.
- Response routing:
  - m_ack_o = {MASTER_NUM{s_ack_i}} & grant_q; m_err_o likewise.
  - m_dat_o = s_dat_i, unqualified.
  - A response arriving with no owner is dropped.
- busy_o = (state==BUSY). grant_o = grant_q.
- Request changes of non-owners during BUSY have no effect.
- Reset mid-BUSY: next cycle grant_q=0, s_cyc_o=0, and last_q returns to its reset value.

Optional Feature:
INTERCON_ARB_TIMEOUT_EN
- Defined:
  - An 8..16-bit counter clears in IDLE and whenever s_ack_i or s_err_i is high.
  - It increments each BUSY cycle with s_stb_o=1.
  - When it equals TIMEOUT, that cycle produces a one-cycle m_err_o[owner]=1 and timeout_o=1.
  - Next cycle: s_cyc_o is forced 0, grant is released as in a normal release, state<=IDLE.
  - The owner must drop m_cyc_i afterwards. Until it does, it is treated as a fresh requester.
- Undefined: no counter is built and timeout_o is tied 0.

Decomposition:
- Shared defines header (i2d_soc_defines.v): `INTERCON_MASTER_NUM, state encodings INTERCON_ARB_IDLE / INTERCON_ARB_BUSY, and the default TIMEOUT.
- Sub-module: the existing combinational round-robin `arbiter`, which computes the pick from request and last_q.
- The re-grant fallback and all registers live in intercon_arb_ctrl.

Test Plan (MASTER_NUM=4):
1. After reset, m_cyc_i=4'b0001 with m0 adr=32'h1000 -> grant_o=4'b0001 and s_adr_o=32'h1000 on the next cycle; busy_o=1.
2. m_cyc_i=4'b1111 held, owner drops cyc after one ack -> grants 0001,0010,0100,1000,0001, each separated by one idle cycle.
3. Only m2 requests repeatedly -> grant_o=4'b0100 every time, one IDLE cycle between.
4. s_ack_i=1 while m1 owns -> m_ack_o=4'b0010; s_ack_i=1 in IDLE -> m_ack_o=0.
5. rst_i=1 during a BUSY owned by m3 -> next cycle grant_o=0 and s_cyc_o=0; a following request from m0 and m3 grants m0.
6. With INTERCON_ARB_TIMEOUT_EN, TIMEOUT=8, m0 strobes and the slave never acks -> m_err_o=4'b0001 and timeout_o=1 for one cycle; s_cyc_o=0 the next cycle.
